alu_operand_seq: RTL and testbench

Operand sequencer and result-capture stage that sits directly upstream of the Sum1 increment unit.
- Loads operand A, then operand B plus the select bit, over one narrow load bus using a valid/ready handshake.
- Drives Sum1's a, b and aluflagin ports from registers, captures Sum1's aluresult, and derives zero/carry flags.
- Presents the captured result downstream on a valid/ready handshake.

---
 rtl/alu_operand_seq_if.sv | 25 ++
 rtl/alu_operand_seq.sv | 134 +++++++++++++
 tb/tb_alu_operand_seq.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_seq_if.sv
// Load/result handshake bundle for alu_operand_seq.
// master: load source + result consumer; slave: the sequencer.
interface alu_operand_seq_if #(
  parameter int ancho = 4
);
  logic [ancho-1:0] din;
  logic             op_sel;
  logic             ld_valid;
  logic             ld_ready;
  logic [ancho-1:0] result;
  logic             flag_zero;
  logic             flag_carry;
  logic             res_valid;
  logic             res_ready;

  modport master (
    output din, op_sel, ld_valid, res_ready,
    input  ld_ready, result, flag_zero, flag_carry, res_valid
  );

  modport slave (
    input  din, op_sel, ld_valid, res_ready,
    output ld_ready, result, flag_zero, flag_carry, res_valid
  );
endinterface

// File: rtl/alu_operand_seq.sv
// Operand sequencer / result capture stage feeding a Sum1 increment unit.
// Loads A, then B + select over one load bus, lets the ALU settle one cycle,
// captures result and zero/carry flags, and hands the result downstream.
// Optional macro ALU_OP_COUNT_EN adds a saturating 8-bit op_count output.
module alu_operand_seq #(
  parameter int ancho = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  output logic [ancho-1:0] alu_a,
  output logic [ancho-1:0] alu_b,
  output logic             alu_sel,
  input  logic [ancho-1:0] alu_res,
  output logic             busy,
`ifdef ALU_OP_COUNT_EN
  output logic [7:0]       op_count,
`endif
  alu_operand_seq_if.slave bus
);

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    ISSUE,
    CAPTURE,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;

  logic             ld_ready_c;
  logic             xfer;
  logic             ld_a_en;
  logic             ld_b_en;
  logic             cap_en;
  logic             clr_valid;

  logic [ancho-1:0] result_r;
  logic             flag_zero_r;
  logic             flag_carry_r;
  logic             res_valid_r;
  logic [ancho-1:0] sel_opnd;

  assign ld_ready_c     = (state == LOAD_A) || (state == LOAD_B);
  assign xfer           = bus.ld_valid & ld_ready_c;
  assign sel_opnd       = alu_sel ? alu_b : alu_a;
  assign busy           = (state != LOAD_A);

  assign bus.ld_ready   = ld_ready_c;
  assign bus.result     = result_r;
  assign bus.flag_zero  = flag_zero_r;
  assign bus.flag_carry = flag_carry_r;
  assign bus.res_valid  = res_valid_r;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD_A;
    else        state <= state_nx;
  end

  // Next-state and register-enable decode; abort overrides every state
  always_comb begin
    state_nx  = state;
    ld_a_en   = 1'b0;
    ld_b_en   = 1'b0;
    cap_en    = 1'b0;
    clr_valid = 1'b0;
    if (abort) begin
      state_nx  = LOAD_A;
      clr_valid = 1'b1;
    end else begin
      case (state)
        LOAD_A: if (xfer) begin
          ld_a_en  = 1'b1;
          state_nx = LOAD_B;
        end
        LOAD_B: if (xfer) begin
          ld_b_en  = 1'b1;
          state_nx = ISSUE;
        end
        ISSUE:   state_nx = CAPTURE;
        CAPTURE: begin
          cap_en   = 1'b1;
          state_nx = DONE;
        end
        DONE: if (bus.res_ready) begin
          clr_valid = 1'b1;
          state_nx  = LOAD_A;
        end
        default: state_nx = LOAD_A;
      endcase
    end
  end

  // Operand, result and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a        <= '0;
      alu_b        <= '0;
      alu_sel      <= 1'b0;
      result_r     <= '0;
      flag_zero_r  <= 1'b0;
      flag_carry_r <= 1'b0;
      res_valid_r  <= 1'b0;
    end else begin
      if (ld_a_en) alu_a <= bus.din;
      if (ld_b_en) begin
        alu_b   <= bus.din;
        alu_sel <= bus.op_sel;
      end
      if (cap_en) begin
        result_r     <= alu_res;
        flag_zero_r  <= (alu_res == '0);
        flag_carry_r <= (sel_opnd == '1);
        res_valid_r  <= 1'b1;
      end
      if (clr_valid) res_valid_r <= 1'b0;
    end
  end

`ifdef ALU_OP_COUNT_EN
  logic handoff;
  assign handoff = (state == DONE) & bus.res_ready & ~abort;

  // Completed-operation counter, saturating at 255
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           op_count <= '0;
    else if (handoff && op_count != '1)   op_count <= op_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_alu_operand_seq.sv
// Self-checking bench for alu_operand_seq with a behavioural Sum1 in the loop.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_alu_operand_seq;

  logic       clk;
  logic       rst_n;
  logic       abort;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic       alu_sel;
  logic [3:0] alu_res;
  logic       busy;
`ifdef ALU_OP_COUNT_EN
  logic [7:0] op_count;
`endif

  alu_operand_seq_if #(.ancho(4)) bus ();

  alu_operand_seq #(.ancho(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .abort   (abort),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_sel (alu_sel),
    .alu_res (alu_res),
    .busy    (busy),
`ifdef ALU_OP_COUNT_EN
    .op_count(op_count),
`endif
    .bus     (bus)
  );

  // Sum1: increments the selected operand
  assign alu_res = alu_sel ? 4'(alu_b + 4'd1) : 4'(alu_a + 4'd1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference state: what the outputs must hold between operations
  logic [3:0] m_a, m_b, m_res;
  logic       m_sel, m_z, m_c;
  int         m_count = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_count();
`ifdef ALU_OP_COUNT_EN
    chk("op_count", 32'(op_count), 32'(m_count));
`endif
  endtask

  // Present A and wait (bounded) for it to be taken; returns at the negedge after the A transfer
  task automatic load_a(input logic [3:0] a);
    int n = 0;
    @(negedge clk);
    bus.din = a; bus.ld_valid = 1'b1; bus.op_sel = 1'($urandom);
    while (!bus.ld_ready && n < 20) begin @(negedge clk); n++; end
    chk("ldA_wait", 32'(n < 20), 32'd1);
    @(negedge clk);
    m_a = a;
    chk("busy_loadB", 32'(busy), 32'd1);
    chk("ldrdy_loadB", 32'(bus.ld_ready), 32'd1);
    chk("alu_a_loaded", 32'(alu_a), 32'(a));
  endtask

  // One full operation; the consumer stalls for 'stall' cycles while the load bus chatters
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic s, input int unsigned stall);
    logic [3:0] opnd;
    opnd = s ? b : a;
    load_a(a);
    bus.din = b; bus.op_sel = s;
    @(negedge clk);                     // B transferred on the edge just passed
    bus.ld_valid = 1'b0;
    m_b = b; m_sel = s;
    chk("rv_edge1", 32'(bus.res_valid), 32'd0);
    chk("ldrdy_issue", 32'(bus.ld_ready), 32'd0);
    @(negedge clk);
    chk("rv_edge2", 32'(bus.res_valid), 32'd0);
    @(negedge clk);
    m_res = 4'(opnd + 4'd1);
    m_z   = (m_res == 4'd0);
    m_c   = (opnd == 4'hF);
    chk("rv_capture", 32'(bus.res_valid), 32'd1);
    chk("result", 32'(bus.result), 32'(m_res));
    chk("flag_zero", 32'(bus.flag_zero), 32'(m_z));
    chk("flag_carry", 32'(bus.flag_carry), 32'(m_c));
    for (int unsigned i = 0; i < stall; i++) begin
      bus.ld_valid = 1'(i % 2); bus.din = 4'($urandom);
      @(negedge clk);
      chk("rv_hold", 32'(bus.res_valid), 32'd1);
      chk("result_hold", 32'(bus.result), 32'(m_res));
      chk("ldrdy_hold", 32'(bus.ld_ready), 32'd0);
      chk("alu_a_hold", 32'(alu_a), 32'(a));
    end
    bus.ld_valid = 1'b0; bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    if (m_count < 255) m_count++;
    chk("rv_handoff", 32'(bus.res_valid), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
    chk("result_kept", 32'(bus.result), 32'(m_res));
    chk("alu_b_kept", 32'(alu_b), 32'(b));
    chk("alu_sel_kept", 32'(alu_sel), 32'(s));
    chk_count();
  endtask

  // where: 0 = abort with the B transfer, 1 = abort in CAPTURE, 2 = abort with res_ready in DONE
  task automatic abort_op(input logic [3:0] a, input logic [3:0] b, input logic s, input int where);
    load_a(a);
    bus.din = b; bus.op_sel = s;
    if (where == 0) begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0; bus.ld_valid = 1'b0;
      chk("ab0_busy", 32'(busy), 32'd0);
      chk("ab0_alu_b", 32'(alu_b), 32'(m_b));
      chk("ab0_alu_sel", 32'(alu_sel), 32'(m_sel));
    end else begin
      @(negedge clk);
      bus.ld_valid = 1'b0;
      m_b = b; m_sel = s;
      @(negedge clk);                   // now in the capture cycle
      if (where == 1) begin
        abort = 1'b1;
      end else begin
        @(negedge clk);
        m_res = 4'((s ? b : a) + 4'd1);
        m_z   = (m_res == 4'd0);
        m_c   = ((s ? b : a) == 4'hF);
        chk("ab2_rv", 32'(bus.res_valid), 32'd1);
        abort = 1'b1; bus.res_ready = 1'b1;
      end
      @(negedge clk);
      abort = 1'b0; bus.res_ready = 1'b0;
    end
    chk("ab_rv", 32'(bus.res_valid), 32'd0);
    chk("ab_result", 32'(bus.result), 32'(m_res));
    chk("ab_flag_zero", 32'(bus.flag_zero), 32'(m_z));
    chk("ab_flag_carry", 32'(bus.flag_carry), 32'(m_c));
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_ldrdy", 32'(bus.ld_ready), 32'd1);
    chk_count();
  endtask

  initial begin
    rst_n = 1'b0; abort = 1'b0;
    bus.din = '0; bus.op_sel = 1'b0; bus.ld_valid = 1'b0; bus.res_ready = 1'b0;
    m_a = '0; m_b = '0; m_sel = 1'b0; m_res = '0; m_z = 1'b0; m_c = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ldrdy", 32'(bus.ld_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);

    // Reset asserted mid-LOAD_B with a word on the bus
    load_a(4'd5);
    bus.din = 4'd6;
    #2 rst_n = 1'b0;
    #1;
    m_a = '0;
    chk("arst_alu_a", 32'(alu_a), 32'd0);
    chk("arst_alu_b", 32'(alu_b), 32'd0);
    chk("arst_alu_sel", 32'(alu_sel), 32'd0);
    chk("arst_result", 32'(bus.result), 32'd0);
    chk("arst_fz", 32'(bus.flag_zero), 32'd0);
    chk("arst_fc", 32'(bus.flag_carry), 32'd0);
    chk("arst_rv", 32'(bus.res_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk_count();
    @(negedge clk);
    bus.ld_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ldrdy", 32'(bus.ld_ready), 32'd1);
    chk("rel_busy", 32'(busy), 32'd0);

    // Directed operations
    run_op(4'd3, 4'd9, 1'b0, 0);
    run_op(4'd2, 4'd15, 1'b1, 0);
    chk("retain_a", 32'(alu_a), 32'd2);
    chk("retain_b", 32'(alu_b), 32'd15);
    run_op(4'd7, 4'd1, 1'b0, 5);
    abort_op(4'd4, 4'd10, 1'b0, 1);
    run_op(4'd15, 4'd0, 1'b0, 1);

    // Abort with a word offered in LOAD_A: word discarded, state unchanged
    @(negedge clk);
    bus.ld_valid = 1'b1; bus.din = 4'd11; abort = 1'b1;
    @(negedge clk);
    bus.ld_valid = 1'b0; abort = 1'b0;
    chk("abA_alu_a", 32'(alu_a), 32'(m_a));
    chk("abA_busy", 32'(busy), 32'd0);

    abort_op(4'd8, 4'd3, 1'b1, 0);
    abort_op(4'd6, 4'd14, 1'b1, 2);

    // Randomized operations and aborts
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0)
        abort_op(4'($urandom), 4'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
      else
        run_op(4'($urandom), 4'($urandom), 1'($urandom), $urandom_range(0, 3));
    end

`ifdef ALU_OP_COUNT_EN
    for (int i = 0; i < 260; i++) begin
      run_op(4'($urandom), 4'($urandom), 1'($urandom), 0);
      if (i % 50 == 0) abort_op(4'($urandom), 4'($urandom), 1'($urandom), 2);
    end
    chk("op_count_sat", 32'(op_count), 32'd255);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, compared %0d", compared);
    $fatal(1, "time limit");
  end

endmodule
